// File: rtl/seq_shifter_unit.sv
// Multi-cycle shifter/rotator (SLL/SRL/SRA/ROL/ROR) moving up to STEP bits per cycle, with carry/zero/err flags.
// Latency: out_valid from cycle N+1+ceil(amt/STEP) after acceptance in cycle N; N+1 for amt==0 or a reserved op.
// Backpressure: result holds in DONE until out_ready; one op in flight, in_ready only in IDLE.
module seq_shifter_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic             busy
);
    localparam int AMT_W = $clog2(WIDTH);
    // count never exceeds WIDTH-1, so clamping STEP there keeps min(count, STEP) unchanged
    localparam int STEP_C = (STEP >= WIDTH) ? WIDTH - 1 : STEP;
    localparam logic [AMT_W-1:0] STEP_V = AMT_W'(STEP_C);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] count_q;
    logic [AMT_W-1:0] amt;
    logic [AMT_W-1:0] step_amt;
    logic [AMT_W-1:0] step_m1;
    logic [AMT_W-1:0] rot_back;
    logic             reserved_in;
    logic [WIDTH-1:0] pre_l, pre_r, rot_l, rot_r;
    logic [WIDTH-1:0] shift_r;
    logic             shift_c;
    logic             unused_b;

    assign amt         = b[AMT_W-1:0];
    assign unused_b    = ^b[WIDTH-1:AMT_W];
    assign reserved_in = (op > OP_ROR);
    assign in_ready    = (state_q == IDLE);
    assign busy        = !in_ready;
    assign out_valid   = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (amt == '0 || reserved_in) ? DONE : SHIFT;
            SHIFT:   if (count_q == step_amt) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // step_amt is 1..WIDTH-1 whenever SHIFT uses it, so -step_amt wraps to WIDTH-step_amt
    always_comb begin
        step_amt = (count_q < STEP_V) ? count_q : STEP_V;
        step_m1  = step_amt - AMT_W'(1);
        rot_back = '0 - step_amt;
        pre_l    = r << step_m1;
        pre_r    = r >> step_m1;
        rot_l    = (r << step_amt) | (r >> rot_back);
        rot_r    = (r >> step_amt) | (r << rot_back);
        shift_r  = r;
        shift_c  = carry;
        case (op_q)
            OP_SLL: begin shift_r = r << step_amt; shift_c = pre_l[WIDTH-1]; end
            OP_SRL: begin shift_r = r >> step_amt; shift_c = pre_r[0]; end
            OP_SRA: begin shift_r = $unsigned($signed(r) >>> step_amt); shift_c = pre_r[0]; end
            OP_ROL: begin shift_r = rot_l; shift_c = rot_l[0]; end
            OP_ROR: begin shift_r = rot_r; shift_c = rot_r[WIDTH-1]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r       <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            err     <= 1'b0;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    r       <= a;
                    op_q    <= op;
                    count_q <= amt;
                    carry   <= 1'b0;
                    err     <= reserved_in;
                    zero    <= (a == '0);
                end
                SHIFT: begin
                    r       <= shift_r;
                    carry   <= shift_c;
                    zero    <= (shift_r == '0);
                    count_q <= count_q - step_amt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shifter_unit.sv
// Bench for seq_shifter_unit: three instances (STEP 1, 4, 16) checked against an arithmetic reference model.
module tb_seq_shifter_unit;
    localparam int W = 16;
    localparam int STEPS [3] = '{1, 4, 16};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a_s = '0, b_s = '0;
    logic [2:0]  op_s = '0;
    logic        in_valid_v [3];
    logic        out_ready_v[3];
    logic        in_ready_v [3];
    logic        out_valid_v[3];
    logic [15:0] r_v        [3];
    logic        carry_v    [3];
    logic        zero_v     [3];
    logic        err_v      [3];
    logic        busy_v     [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_shifter_unit #(.WIDTH(W), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_s), .b(b_s), .op(op_s), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .r(r_v[0]), .carry(carry_v[0]), .zero(zero_v[0]), .err(err_v[0]), .busy(busy_v[0]));
    seq_shifter_unit #(.WIDTH(W), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_s), .b(b_s), .op(op_s), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .r(r_v[1]), .carry(carry_v[1]), .zero(zero_v[1]), .err(err_v[1]), .busy(busy_v[1]));
    seq_shifter_unit #(.WIDTH(W), .STEP(16)) u_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_s), .b(b_s), .op(op_s), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .r(r_v[2]), .carry(carry_v[2]), .zero(zero_v[2]), .err(err_v[2]), .busy(busy_v[2]));

    // Reference: whole-operation result straight from the mode definitions.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                                  output logic [15:0] r, output logic c, output logic e);
        int amt;
        amt = int'(b[3:0]);
        r = a; c = 1'b0; e = 1'b0;
        case (op)
            3'd0: begin r = a << amt; if (amt != 0) c = a[16-amt]; end
            3'd1: begin r = a >> amt; if (amt != 0) c = a[amt-1]; end
            3'd2: begin r = $unsigned($signed(a) >>> amt); if (amt != 0) c = a[amt-1]; end
            3'd3: if (amt != 0) begin r = (a << amt) | (a >> (16 - amt)); c = r[0]; end
            3'd4: if (amt != 0) begin r = (a >> amt) | (a << (16 - amt)); c = r[15]; end
            default: e = 1'b1;
        endcase
    endfunction

    function automatic int exp_latency(input int idx, input logic [15:0] b, input logic [2:0] op);
        int amt;
        amt = int'(b[3:0]);
        if (amt == 0 || op > 3'd4) return 1;
        return 1 + (amt + STEPS[idx] - 1) / STEPS[idx];
    endfunction

    // Called at a negedge with the chosen instance idle and out_ready high.
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [15:0] er;
        logic ec, ee;
        int lat, el;
        model(a, b, op, er, ec, ee);
        el = exp_latency(idx, b, op);
        a_s = a; b_s = b; op_s = op; in_valid_v[idx] = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_v[idx] = 1'b0;
        a_s = 16'($urandom); b_s = 16'($urandom);
        lat = 1;
        while (!out_valid_v[idx] && lat < 60) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        checks++;
        if (lat !== el) begin failures++; $display("FAIL latency dut%0d op=%0d a=%h b=%h got=%0d exp=%0d", idx, op, a, b, lat, el); end
        checks++;
        if (r_v[idx] !== er) begin failures++; $display("FAIL r dut%0d op=%0d a=%h b=%h got=%h exp=%h", idx, op, a, b, r_v[idx], er); end
        checks++;
        if (carry_v[idx] !== ec) begin failures++; $display("FAIL carry dut%0d op=%0d a=%h b=%h got=%b exp=%b", idx, op, a, b, carry_v[idx], ec); end
        checks++;
        if (zero_v[idx] !== (er == 16'h0)) begin failures++; $display("FAIL zero dut%0d op=%0d a=%h b=%h got=%b exp=%b", idx, op, a, b, zero_v[idx], er == 16'h0); end
        checks++;
        if (err_v[idx] !== ee) begin failures++; $display("FAIL err dut%0d op=%0d got=%b exp=%b", idx, op, err_v[idx], ee); end
        @(posedge clk); @(negedge clk);
        checks++;
        if (in_ready_v[idx] !== 1'b1 || out_valid_v[idx] !== 1'b0) begin
            failures++; $display("FAIL release dut%0d in_ready=%b out_valid=%b exp 1/0", idx, in_ready_v[idx], out_valid_v[idx]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin in_valid_v[i] = 1'b1; out_ready_v[i] = 1'b1; end
        a_s = 16'hBEEF; b_s = 16'h0003; op_s = 3'd0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b1 || out_valid_v[i] !== 1'b0 || r_v[i] !== 16'h0 ||
                carry_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || zero_v[i] !== 1'b0 || err_v[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset dut%0d rdy=%b vld=%b r=%h c=%b busy=%b z=%b e=%b exp 1 0 0000 0 0 0 0",
                         i, in_ready_v[i], out_valid_v[i], r_v[i], carry_v[i], busy_v[i], zero_v[i], err_v[i]);
            end
            in_valid_v[i] = 1'b0;
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_sll_sweep();
        for (int s = 0; s < 16; s++) run_op(0, 16'h0001, 16'(s), 3'd0);
    endtask

    task automatic test_directed();
        run_op(1, 16'h8000, 16'd15, 3'd2);
        run_op(1, 16'h0003, 16'd2, 3'd1);
        run_op(0, 16'h8001, 16'd1, 3'd3);
        run_op(0, 16'h0001, 16'd1, 3'd4);
        run_op(0, 16'h0001, 16'h0011, 3'd0);
        run_op(0, 16'h0001, 16'h0010, 3'd0);
        run_op(0, 16'h1234, 16'h0007, 3'd5);
        run_op(2, 16'hA5C3, 16'd15, 3'd3);
        run_op(2, 16'h8421, 16'd9, 3'd2);
        run_op(1, 16'hFFFF, 16'hFFF0, 3'd7);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            run_op(int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] er;
        logic ec, ee;
        int t;
        model(16'h00F0, 16'd5, 3'd1, er, ec, ee);
        out_ready_v[0] = 1'b0;
        a_s = 16'h00F0; b_s = 16'd5; op_s = 3'd1; in_valid_v[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_v[0] = 1'b0;
        t = 0;
        while (!out_valid_v[0] && t < 60) begin @(posedge clk); @(negedge clk); t++; end
        checks++;
        if (out_valid_v[0] !== 1'b1) begin failures++; $display("FAIL bp_wait out_valid=%b exp 1", out_valid_v[0]); end
        for (int k = 0; k < 3; k++) begin
            in_valid_v[0] = ~in_valid_v[0]; a_s = 16'($urandom); b_s = 16'($urandom_range(1, 15));
            @(posedge clk); @(negedge clk);
            checks++;
            if (r_v[0] !== er || carry_v[0] !== ec || zero_v[0] !== (er == 16'h0) ||
                in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cyc%0d r=%h c=%b z=%b rdy=%b vld=%b exp %h %b %b 0 1",
                         k, r_v[0], carry_v[0], zero_v[0], in_ready_v[0], out_valid_v[0], er, ec, er == 16'h0);
            end
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || r_v[0] !== er) begin
            failures++; $display("FAIL bp_release rdy=%b vld=%b r=%h exp 1 0 %h", in_ready_v[0], out_valid_v[0], r_v[0], er);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        a_s = 16'h0001; b_s = 16'd8; op_s = 3'd0; in_valid_v[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b1) begin failures++; $display("FAIL mid_busy busy=%b exp 1", busy_v[0]); end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || r_v[0] !== 16'h0) begin
            failures++; $display("FAIL mid_reset rdy=%b vld=%b r=%h exp 1 0 0000", in_ready_v[0], out_valid_v[0], r_v[0]);
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid_v[0]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_valid out_valid rose=%b exp 0", seen); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b1; end
        @(negedge clk);
        test_reset();
        test_sll_sweep();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
